// File: rtl/cipher_pkg.sv
`default_nettype none
// cipher_pkg -- shared sizes and controller state encoding for the cipher RAM path.
// Rev 1.0
package cipher_pkg;

  localparam int BLOCK_BYTES = 8;
  localparam int KEY_BYTES   = 16;
  localparam int BLOCK_W     = 8 * BLOCK_BYTES;
  localparam int KEY_W       = 8 * KEY_BYTES;
  localparam int ADDR_W      = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SEND     = 3'd2,
    WAIT_RES = 3'd3,
    STORE    = 3'd4,
    DONE     = 3'd5
  } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/cipher_ram_ctrl.sv
`default_nettype none
// cipher_ram_ctrl -- reads plaintext/key RAMs, hands the packed block to the cipher core,
// writes the core result back to the result RAM byte by byte.  Rev 1.0
module cipher_ram_ctrl #(
  parameter int DATA_BYTES = cipher_pkg::BLOCK_BYTES,
  parameter int KEY_BYTES  = cipher_pkg::KEY_BYTES,
  parameter logic [cipher_pkg::ADDR_W-1:0] PT_BASE  = '0,
  parameter logic [cipher_pkg::ADDR_W-1:0] KEY_BASE = '0,
  parameter logic [cipher_pkg::ADDR_W-1:0] DST_BASE = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [cipher_pkg::ADDR_W-1:0] pt_addr,
  input  logic [7:0]                    pt_dout,
  output logic [cipher_pkg::ADDR_W-1:0] key_addr,
  input  logic [7:0]                    key_dout,
  output logic                          ct_we,
  output logic [cipher_pkg::ADDR_W-1:0] ct_addr,
  output logic [7:0]                    ct_din,
  output logic                          blk_valid,
  input  logic                          blk_ready,
  output logic [8*DATA_BYTES-1:0]       blk_data,
  output logic [8*KEY_BYTES-1:0]        key_data,
  input  logic                          res_valid,
  output logic                          res_ready,
  input  logic [8*DATA_BYTES-1:0]       res_data
);
  import cipher_pkg::*;

  localparam int CNT_W = $clog2(KEY_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD_END  = CNT_W'(KEY_BYTES);
  localparam logic [CNT_W-1:0] CNT_STORE_END = CNT_W'(DATA_BYTES - 1);

  ctrl_state_t              state, state_next;
  logic [CNT_W-1:0]         cnt, cnt_next;
  logic [8*DATA_BYTES-1:0]  res_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = 1'b0;
    done       = 1'b0;
    blk_valid  = 1'b0;
    res_ready  = 1'b0;
    ct_we      = 1'b0;
    ct_addr    = '0;
    ct_din     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          cnt_next   = '0;
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (cnt == CNT_LOAD_END) begin
          state_next = SEND;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      SEND: begin
        busy      = 1'b1;
        blk_valid = 1'b1;
        if (blk_ready) state_next = WAIT_RES;
      end
      WAIT_RES: begin
        busy      = 1'b1;
        res_ready = 1'b1;
        if (res_valid) begin
          state_next = STORE;
          cnt_next   = '0;
        end
      end
      STORE: begin
        busy    = 1'b1;
        ct_we   = 1'b1;
        ct_addr = DST_BASE + ADDR_W'(cnt);
        ct_din  = res_q[8*(DATA_BYTES - 1 - int'(cnt)) +: 8];
        if (cnt == CNT_STORE_END) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Addresses are registered one step ahead of the capture, matching the RAM's
  // one-cycle read latency: byte n is presented at cnt=n and captured at cnt=n+1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pt_addr  <= '0;
      key_addr <= '0;
      blk_data <= '0;
      key_data <= '0;
      res_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pt_addr  <= PT_BASE;
            key_addr <= KEY_BASE;
          end
        end
        LOAD: begin
          if (int'(cnt) + 1 < KEY_BYTES)
            key_addr <= KEY_BASE + ADDR_W'(cnt) + ADDR_W'(1);
          if (int'(cnt) + 1 < DATA_BYTES)
            pt_addr <= PT_BASE + ADDR_W'(cnt) + ADDR_W'(1);
          if (cnt != '0)
            key_data[8*(KEY_BYTES - int'(cnt)) +: 8] <= key_dout;
          if (cnt != '0 && int'(cnt) <= DATA_BYTES)
            blk_data[8*(DATA_BYTES - int'(cnt)) +: 8] <= pt_dout;
        end
        WAIT_RES: begin
          if (res_valid) res_q <= res_data;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cipher_ram_ctrl.sv
`default_nettype none
// tb_cipher_ram_ctrl -- vector table, reset/corner sequences and randomized operations
// checked against a byte-level model of the controller's RAM traffic.
module tb_cipher_ram_ctrl;

  localparam logic [7:0] DST1 = 8'hFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        blk_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic [63:0] res_data = '0;

  always #5 clk = ~clk;

  logic         busy_w[2], done_w[2], ct_we_w[2], blk_valid_w[2], res_ready_w[2];
  logic [7:0]   pt_addr_w[2], key_addr_w[2], ct_addr_w[2], ct_din_w[2];
  logic [7:0]   pt_dout_w[2], key_dout_w[2];
  logic [63:0]  blk_w[2];
  logic [127:0] key_w[2];

  logic [7:0]   pt_mem[256];
  logic [7:0]   key_mem[256];
  logic [15:0]  wlog0[$];
  logic [15:0]  wlog1[$];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pt_dout_w[i]  <= pt_mem[pt_addr_w[i]];
      key_dout_w[i] <= key_mem[key_addr_w[i]];
    end
    if (ct_we_w[0] === 1'b1) wlog0.push_back({ct_addr_w[0], ct_din_w[0]});
    if (ct_we_w[1] === 1'b1) wlog1.push_back({ct_addr_w[1], ct_din_w[1]});
  end

  cipher_ram_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_w[0]), .done(done_w[0]),
    .pt_addr(pt_addr_w[0]), .pt_dout(pt_dout_w[0]), .key_addr(key_addr_w[0]), .key_dout(key_dout_w[0]),
    .ct_we(ct_we_w[0]), .ct_addr(ct_addr_w[0]), .ct_din(ct_din_w[0]),
    .blk_valid(blk_valid_w[0]), .blk_ready(blk_ready), .blk_data(blk_w[0]), .key_data(key_w[0]),
    .res_valid(res_valid), .res_ready(res_ready_w[0]), .res_data(res_data)
  );

  cipher_ram_ctrl #(.DST_BASE(DST1)) u_dut_fc (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_w[1]), .done(done_w[1]),
    .pt_addr(pt_addr_w[1]), .pt_dout(pt_dout_w[1]), .key_addr(key_addr_w[1]), .key_dout(key_dout_w[1]),
    .ct_we(ct_we_w[1]), .ct_addr(ct_addr_w[1]), .ct_din(ct_din_w[1]),
    .blk_valid(blk_valid_w[1]), .blk_ready(blk_ready), .blk_data(blk_w[1]), .key_data(key_w[1]),
    .res_valid(res_valid), .res_ready(res_ready_w[1]), .res_data(res_data)
  );

  int n_cmp = 0;
  int n_fail = 0;

  int           cyc[2], dn[2], bv[2], rr[2];
  logic [63:0]  got_blk[2];
  logic [127:0] got_key[2];
  bit           unstable[2];
  bit           tmo;

  typedef struct {
    int           bs;
    int           rs;
    logic [63:0]  res;
    bit           glitch;
    logic [63:0]  exp_blk;
    logic [127:0] exp_key;
    int           exp_cyc;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_blk();
    logic [63:0] v = '0;
    for (int k = 0; k < 8; k++) v = {v[55:0], pt_mem[k]};
    return v;
  endfunction

  function automatic logic [127:0] ref_key();
    logic [127:0] v = '0;
    for (int k = 0; k < 16; k++) v = {v[119:0], key_mem[k]};
    return v;
  endfunction

  task automatic check_idle(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s[%0d] ctrl", tag, i),
          128'({busy_w[i], done_w[i], ct_we_w[i], blk_valid_w[i], res_ready_w[i]}), 128'(0));
      chk($sformatf("%s[%0d] addr", tag, i),
          128'({pt_addr_w[i], key_addr_w[i], ct_addr_w[i], ct_din_w[i]}), 128'(0));
      chk($sformatf("%s[%0d] blk_data", tag, i), 128'(blk_w[i]), 128'(0));
      chk($sformatf("%s[%0d] key_data", tag, i), key_w[i], 128'(0));
    end
  endtask

  task automatic check_writes(input logic [15:0] q[$], input logic [7:0] base,
                              input logic [63:0] res, input int n, input string tag);
    logic [7:0] a;
    chk_int({tag, " write count"}, q.size(), n);
    for (int k = 0; k < n && k < q.size(); k++) begin
      a = base + 8'(k);
      chk($sformatf("%s write %0d", tag, k), 128'(q[k]), 128'({a, res[8*(7-k) +: 8]}));
    end
  endtask

  // One block operation with a core model that stalls the handshakes by bs/rs cycles.
  task automatic run_op(input int bs, input int rs, input logic [63:0] res, input bit glitch);
    int sv = 0;
    int wv = 0;
    int post = 0;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 0; dn[i] = 0; bv[i] = 0; rr[i] = 0;
      got_blk[i] = '0; got_key[i] = '0; unstable[i] = 1'b0;
    end
    wlog0.delete();
    wlog1.delete();
    res_data  = res;
    blk_ready = (bs == 0);
    res_valid = (rs == 0);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tmo   = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (busy_w[i] === 1'b1) cyc[i]++;
        if (done_w[i] === 1'b1) dn[i]++;
        if (res_ready_w[i] === 1'b1) rr[i]++;
        if (blk_valid_w[i] === 1'b1) begin
          if (bv[i] == 0) begin
            got_blk[i] = blk_w[i];
            got_key[i] = key_w[i];
          end else if (blk_w[i] !== got_blk[i] || key_w[i] !== got_key[i]) begin
            unstable[i] = 1'b1;
          end
          bv[i]++;
        end
      end
      if (blk_valid_w[0] === 1'b1) begin
        blk_ready = (sv >= bs);
        sv++;
      end else begin
        blk_ready = (bs == 0);
      end
      if (res_ready_w[0] === 1'b1) begin
        res_valid = (wv >= rs);
        wv++;
      end else begin
        res_valid = (rs == 0);
      end
      start = glitch && (c == 5 || c == 22);
      if (dn[0] > 0) post++;
      if (post > 3) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string tag, input int exp_cyc, input logic [63:0] exp_blk,
                          input logic [127:0] exp_key, input logic [63:0] res,
                          input int bs, input int rs);
    chk_int({tag, " timeout"}, int'(tmo), 0);
    for (int i = 0; i < 2; i++) begin
      chk_int($sformatf("%s[%0d] busy cycles", tag, i), cyc[i], exp_cyc);
      chk($sformatf("%s[%0d] blk_data", tag, i), 128'(got_blk[i]), 128'(exp_blk));
      chk($sformatf("%s[%0d] key_data", tag, i), got_key[i], exp_key);
      chk_int($sformatf("%s[%0d] done pulses", tag, i), dn[i], 1);
      chk_int($sformatf("%s[%0d] blk_valid cycles", tag, i), bv[i], bs + 1);
      chk_int($sformatf("%s[%0d] res_ready cycles", tag, i), rr[i], rs + 1);
      chk_int($sformatf("%s[%0d] blk stable", tag, i), int'(unstable[i]), 0);
    end
    check_writes(wlog0, 8'h00, res, 8, {tag, " dst00"});
    check_writes(wlog1, DST1, res, 8, {tag, " dstFC"});
  endtask

  initial begin
    logic [63:0] res;
    int bs;
    int rs;

    for (int a = 0; a < 256; a++) begin
      pt_mem[a]  = 8'h00;
      key_mem[a] = 8'h00;
    end
    for (int k = 0; k < 8; k++)  pt_mem[k]  = 8'((k + 1) * 17);
    for (int k = 0; k < 16; k++) key_mem[k] = 8'(k);

    tbl[0] = '{0, 0, 64'hA1B2C3D4E5F60718, 1'b0, 64'h1122334455667788,
               128'h000102030405060708090A0B0C0D0E0F, 28};
    tbl[1] = '{5, 7, 64'h0123456789ABCDEF, 1'b0, 64'h1122334455667788,
               128'h000102030405060708090A0B0C0D0E0F, 40};
    tbl[2] = '{0, 0, 64'h5A5AA5A5F00FC33C, 1'b1, 64'h1122334455667788,
               128'h000102030405060708090A0B0C0D0E0F, 28};
    tbl[3] = '{2, 3, 64'hFEDCBA9876543210, 1'b0, 64'h1122334455667788,
               128'h000102030405060708090A0B0C0D0E0F, 33};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      run_op(tbl[t].bs, tbl[t].rs, tbl[t].res, tbl[t].glitch);
      check_op($sformatf("vec%0d", t), tbl[t].exp_cyc, tbl[t].exp_blk, tbl[t].exp_key,
               tbl[t].res, tbl[t].bs, tbl[t].rs);
    end

    // Reset sampled at the edge that would start STORE cnt=3: only bytes 0..2 land.
    wlog0.delete();
    wlog1.delete();
    res = 64'hCAFEF00D12345678;
    res_data  = res;
    blk_ready = 1'b1;
    res_valid = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tmo   = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (ct_we_w[0] === 1'b1 && ct_addr_w[0] == 8'd2) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
    chk_int("rst_mid reach store", int'(tmo), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("rst_mid");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid stays idle", 128'({busy_w[0], busy_w[1], ct_we_w[0], ct_we_w[1]}), 128'(0));
    check_writes(wlog0, 8'h00, res, 3, "rst_mid dst00");
    check_writes(wlog1, DST1, res, 3, "rst_mid dstFC");

    run_op(0, 0, 64'h0F1E2D3C4B5A6978, 1'b0);
    check_op("after_rst", 28, 64'h1122334455667788,
             128'h000102030405060708090A0B0C0D0E0F, 64'h0F1E2D3C4B5A6978, 0, 0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++)  pt_mem[k]  = 8'($urandom);
      for (int k = 0; k < 16; k++) key_mem[k] = 8'($urandom);
      res = {$urandom, $urandom};
      bs  = int'($urandom_range(0, 4));
      rs  = int'($urandom_range(0, 4));
      run_op(bs, rs, res, 1'b0);
      check_op($sformatf("rand%0d", r), 28 + bs + rs, ref_blk(), ref_key(), res, bs, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
